// File: rtl/tdm_mac_fir.sv
// Time-multiplexed multi-channel FIR: one shared MAC iterated ORDER times per sample,
// runtime-writable coefficients. Define FIR_SAT_EN to saturate instead of truncate the output.
module tdm_mac_fir #(
  parameter int DATAWIDTH  = 16,
  parameter int COEFFWIDTH = 18,
  parameter int ORDER      = 41,
  parameter int CHANNELS   = 2,
  parameter int OUTSHIFT   = 16,
  parameter int ACCWIDTH   = DATAWIDTH + COEFFWIDTH + $clog2(ORDER),
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW = $clog2(ORDER)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATAWIDTH-1:0]  in_data,
  input  logic [CW-1:0]         in_chan,
  output logic                  out_valid,
  output logic [DATAWIDTH-1:0]  out_data,
  output logic [CW-1:0]         out_chan,
  input  logic                  coef_we,
  input  logic [AW-1:0]         coef_addr,
  input  logic [COEFFWIDTH-1:0] coef_data,
  output logic                  busy
);

  localparam int PW = DATAWIDTH + COEFFWIDTH;
  localparam logic [AW-1:0] LAST_A = AW'(ORDER - 1);
  localparam logic [AW-1:0] ONE_A  = AW'(1);
  localparam logic signed [COEFFWIDTH-1:0] COEF_ONE =
    {{(COEFFWIDTH-1){1'b0}}, 1'b1} << OUTSHIFT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                        state_r;
  logic signed [DATAWIDTH-1:0]   x_r      [CHANNELS][ORDER];
  logic signed [COEFFWIDTH-1:0]  coef_r   [ORDER];
  logic [AW-1:0]                 wr_ptr_r [CHANNELS];
  logic [AW-1:0]                 k_r;
  logic [AW-1:0]                 rd_idx_r;
  logic [CW-1:0]                 chan_r;
  logic signed [ACCWIDTH-1:0]    acc_r;

  logic                          chan_ok_s;
  logic                          addr_ok_s;
  logic                          accept_s;
  logic                          coef_wr_s;
  logic signed [PW-1:0]          coef_ext_s;
  logic signed [PW-1:0]          x_ext_s;
  logic signed [PW-1:0]          prod_s;
  logic signed [ACCWIDTH-1:0]    acc_next_s;
  logic [AW-1:0]                 rd_prev_s;
  logic [DATAWIDTH-1:0]          out_next_s;

  assign chan_ok_s = (int'(in_chan) < CHANNELS);
  assign addr_ok_s = (int'(coef_addr) < ORDER);
  assign accept_s  = (state_r == IDLE) && in_valid && chan_ok_s;
  assign coef_wr_s = (state_r == IDLE) && coef_we && addr_ok_s;

  // Both operands sign-extended to the full product width so the multiply is exact.
  assign coef_ext_s = {{DATAWIDTH{coef_r[k_r][COEFFWIDTH-1]}}, coef_r[k_r]};
  assign x_ext_s    = {{COEFFWIDTH{x_r[chan_r][rd_idx_r][DATAWIDTH-1]}}, x_r[chan_r][rd_idx_r]};
  assign prod_s     = coef_ext_s * x_ext_s;
  assign acc_next_s = acc_r + {{(ACCWIDTH-PW){prod_s[PW-1]}}, prod_s};
  assign rd_prev_s  = (rd_idx_r == {AW{1'b0}}) ? LAST_A : (rd_idx_r - ONE_A);

`ifdef FIR_SAT_EN
  function automatic logic [DATAWIDTH-1:0] sat_fn(input logic signed [ACCWIDTH-1:0] v);
    logic signed [ACCWIDTH-1:0] max_v;
    logic signed [ACCWIDTH-1:0] min_v;
    max_v = {{(ACCWIDTH-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
    min_v = {{(ACCWIDTH-DATAWIDTH+1){1'b1}}, {(DATAWIDTH-1){1'b0}}};
    if (v > max_v) begin
      sat_fn = {1'b0, {(DATAWIDTH-1){1'b1}}};
    end else if (v < min_v) begin
      sat_fn = {1'b1, {(DATAWIDTH-1){1'b0}}};
    end else begin
      sat_fn = v[DATAWIDTH-1:0];
    end
  endfunction

  assign out_next_s = sat_fn(acc_r >>> OUTSHIFT);
`else
  assign out_next_s = DATAWIDTH'(acc_r >>> OUTSHIFT);
`endif

  // Coefficient RAM; reset leaves an identity filter, writes only land while idle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int j = 0; j < ORDER; j++) begin
        coef_r[j] <= (j == 0) ? COEF_ONE : {COEFFWIDTH{1'b0}};
      end
    end else if (coef_wr_s) begin
      coef_r[coef_addr] <= coef_data;
    end
  end

  // Per-channel circular delay lines; the pointer advances once the result is emitted.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr_r[c] <= {AW{1'b0}};
        for (int j = 0; j < ORDER; j++) begin
          x_r[c][j] <= {DATAWIDTH{1'b0}};
        end
      end
    end else begin
      if (accept_s) begin
        x_r[in_chan][wr_ptr_r[in_chan]] <= in_data;
      end
      if (state_r == OUT) begin
        wr_ptr_r[chan_r] <= (wr_ptr_r[chan_r] == LAST_A) ? {AW{1'b0}} : (wr_ptr_r[chan_r] + ONE_A);
      end
    end
  end

  // Control FSM and registered outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= {DATAWIDTH{1'b0}};
      out_chan  <= {CW{1'b0}};
      acc_r     <= {ACCWIDTH{1'b0}};
      k_r       <= {AW{1'b0}};
      rd_idx_r  <= {AW{1'b0}};
      chan_r    <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          out_valid <= 1'b0;
          if (accept_s) begin
            chan_r   <= in_chan;
            acc_r    <= {ACCWIDTH{1'b0}};
            k_r      <= {AW{1'b0}};
            rd_idx_r <= wr_ptr_r[in_chan];
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_r  <= MAC;
          end
        end
        MAC: begin
          acc_r    <= acc_next_s;
          k_r      <= k_r + ONE_A;
          rd_idx_r <= rd_prev_s;
          if (k_r == LAST_A) begin
            state_r <= OUT;
          end
        end
        OUT: begin
          out_data  <= out_next_s;
          out_chan  <= chan_r;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_mac_fir.sv
// Scoreboard bench for tdm_mac_fir: a direct-convolution model queues expected outputs
// as samples are accepted; each scenario task pops and compares when the DUT responds.
module tb_tdm_mac_fir;

  localparam int ORD = 41;
  localparam int NCH = 3;
  localparam int SH  = 16;

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_data = 16'd0;
  logic [1:0]        in_chan = 2'd0;
  logic              out_valid;
  logic [15:0]       out_data;
  logic [1:0]        out_chan;
  logic              coef_we = 1'b0;
  logic [5:0]        coef_addr = 6'd0;
  logic [17:0]       coef_data = 18'd0;
  logic              busy;

  tdm_mac_fir #(.CHANNELS(NCH)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chan(in_chan),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic signed [15:0] data;
    logic [1:0]         chan;
  } exp_t;

  exp_t   sb_q[$];
  longint m_coef[ORD];
  longint m_hist[NCH][ORD];
  int     pass_cnt = 0;
  int     total_cnt = 0;
  int     hs_timeouts = 0;

  function automatic logic signed [15:0] model_out(int ch);
    longint acc;
    acc = 0;
    for (int k = 0; k < ORD; k++) acc += m_coef[k] * m_hist[ch][k];
    acc = acc >>> SH;
`ifdef FIR_SAT_EN
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`endif
    return acc[15:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ORD; k++) m_coef[k] = (k == 0) ? 65536 : 0;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < ORD; k++) m_hist[c][k] = 0;
    sb_q.delete();
  endtask

  task automatic pulse_reset();
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    model_reset();
  endtask

  task automatic send_sample(input logic signed [15:0] d, input logic [1:0] ch,
                             input bit we, input logic [5:0] ca, input logic signed [17:0] cd);
    int n;
    exp_t e;
    n = 0;
    in_valid = 1'b1; in_data = d; in_chan = ch;
    coef_we = we; coef_addr = ca; coef_data = cd;
    while (!in_ready && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (!in_ready) hs_timeouts++;
    @(posedge Clk);
    if (we && int'(ca) < ORD) m_coef[ca] = cd;
    if (int'(ch) < NCH) begin
      for (int j = ORD - 1; j > 0; j--) m_hist[ch][j] = m_hist[ch][j-1];
      m_hist[ch][0] = d;
      e.data = model_out(int'(ch));
      e.chan = ch;
      sb_q.push_back(e);
    end
    @(negedge Clk);
    in_valid = 1'b0;
    coef_we = 1'b0;
  endtask

  task automatic write_coef(input logic [5:0] ca, input logic signed [17:0] cd);
    coef_we = 1'b1; coef_addr = ca; coef_data = cd;
    @(posedge Clk);
    if (int'(ca) < ORD) m_coef[ca] = cd;
    @(negedge Clk);
    coef_we = 1'b0;
  endtask

  task automatic get_output(output bit got, output int lat, output logic signed [15:0] d,
                            output logic [1:0] ch);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge Clk);
      lat++;
    end
    got = out_valid;
    d = out_data;
    ch = out_chan;
    @(negedge Clk);
  endtask

  task automatic watch_quiet(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      @(negedge Clk);
      if (out_valid) seen++;
    end
  endtask

  task automatic test_reset();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 16'd0) $display("FAIL reset_out_data: got %0d want 0", out_data); else pass_cnt++;
    total_cnt++; if (out_chan !== 2'd0) $display("FAIL reset_out_chan: got %0d want 0", out_chan); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_passthrough();
    logic signed [15:0] vals [3];
    bit got; int lat; logic signed [15:0] od; logic [1:0] oc; exp_t e;
    vals = '{16'sd100, -16'sd200, 16'sd300};
    for (int i = 0; i < 3; i++) begin
      send_sample(vals[i], 2'd0, 1'b0, 6'd0, 18'sd0);
      get_output(got, lat, od, oc);
      e = sb_q.pop_front();
      total_cnt++;
      if (!got || od !== e.data || oc !== e.chan)
        $display("FAIL passthrough[%0d]: got valid=%b data=%0d chan=%0d want data=%0d chan=%0d", i, got, od, oc, e.data, e.chan);
      else pass_cnt++;
      total_cnt++;
      if (lat !== 42) $display("FAIL passthrough_latency[%0d]: got %0d want 42", i, lat); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    bit got; int lat; int n; logic signed [15:0] od; logic [1:0] oc; exp_t e;
    send_sample(16'sd1000, 2'd0, 1'b0, 6'd0, 18'sd0);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge Clk);
      n++;
    end
    total_cnt++;
    if (n !== 42 || out_valid !== 1'b1)
      $display("FAIL b2b_ready_return: got cycles=%0d out_valid=%b want 42 and 1", n, out_valid);
    else pass_cnt++;
    e = sb_q.pop_front();
    total_cnt++;
    if (out_data !== e.data) $display("FAIL b2b_first: got %0d want %0d", $signed(out_data), e.data); else pass_cnt++;
    send_sample(-16'sd1000, 2'd0, 1'b0, 6'd0, 18'sd0);
    get_output(got, lat, od, oc);
    e = sb_q.pop_front();
    total_cnt++;
    if (!got || od !== e.data || lat !== 42)
      $display("FAIL b2b_second: got valid=%b data=%0d lat=%0d want data=%0d lat=42", got, od, lat, e.data);
    else pass_cnt++;
  endtask

  task automatic test_impulse();
    bit got; int lat; logic signed [15:0] od; logic [1:0] oc; exp_t e;
    for (int k = 0; k < ORD; k++) write_coef(6'(k), 18'(4 * (k + 1)));
    for (int i = 0; i < ORD; i++) begin
      send_sample((i == 0) ? 16'sd16384 : 16'sd0, 2'd1, 1'b0, 6'd0, 18'sd0);
      get_output(got, lat, od, oc);
      e = sb_q.pop_front();
      total_cnt++;
      if (!got || od !== e.data || oc !== e.chan)
        $display("FAIL impulse[%0d]: got valid=%b data=%0d chan=%0d want data=%0d chan=%0d", i, got, od, oc, e.data, e.chan);
      else pass_cnt++;
    end
  endtask

  task automatic test_channels();
    bit got; int lat; logic signed [15:0] od; logic [1:0] oc; exp_t e;
    pulse_reset();
    for (int k = 0; k < ORD; k++) write_coef(6'(k), 18'(4 * (k + 1)));
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 2; c++) begin
        send_sample((i == 0 && c == 0) ? 16'sd16384 : 16'sd0, 2'(c), 1'b0, 6'd0, 18'sd0);
        get_output(got, lat, od, oc);
        e = sb_q.pop_front();
        total_cnt++;
        if (!got || od !== e.data || oc !== e.chan)
          $display("FAIL channels[%0d.%0d]: got valid=%b data=%0d chan=%0d want data=%0d chan=%0d", i, c, got, od, oc, e.data, e.chan);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_gating();
    bit got; int lat; int seen; logic signed [15:0] od; logic [1:0] oc; exp_t e;
    pulse_reset();
    // coefficient write in the accept cycle must apply to that very sample
    send_sample(16'sd400, 2'd0, 1'b1, 6'd0, 18'sd32768);
    get_output(got, lat, od, oc);
    e = sb_q.pop_front();
    total_cnt++;
    if (!got || od !== e.data) $display("FAIL same_cycle_coef: got valid=%b data=%0d want %0d", got, od, e.data); else pass_cnt++;
    write_coef(6'd0, 18'sd65536);
    send_sample(16'sd111, 2'd0, 1'b0, 6'd0, 18'sd0);
    in_valid = 1'b1; in_data = 16'd999; in_chan = 2'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (i == 3) begin coef_we = 1'b1; coef_addr = 6'd0; coef_data = 18'd0; end
      if (i == 4) coef_we = 1'b0;
      if (i == 5) begin
        total_cnt++;
        if (in_ready !== 1'b0 || busy !== 1'b1)
          $display("FAIL busy_flags: got in_ready=%b busy=%b want 0 and 1", in_ready, busy);
        else pass_cnt++;
      end
    end
    in_valid = 1'b0;
    get_output(got, lat, od, oc);
    e = sb_q.pop_front();
    total_cnt++;
    if (!got || od !== e.data) $display("FAIL held_sample_out: got valid=%b data=%0d want %0d", got, od, e.data); else pass_cnt++;
    watch_quiet(50, seen);
    total_cnt++;
    if (seen !== 0) $display("FAIL no_extra_accept: got %0d outputs want 0", seen); else pass_cnt++;
    send_sample(16'sd222, 2'd0, 1'b0, 6'd0, 18'sd0);
    get_output(got, lat, od, oc);
    e = sb_q.pop_front();
    total_cnt++;
    if (!got || od !== e.data) $display("FAIL busy_coef_ignored: got valid=%b data=%0d want %0d", got, od, e.data); else pass_cnt++;
    send_sample(16'sd555, 2'd3, 1'b0, 6'd0, 18'sd0);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL bad_chan_busy: got %b want 0", busy); else pass_cnt++;
    watch_quiet(60, seen);
    total_cnt++;
    if (seen !== 0) $display("FAIL bad_chan_dropped: got %0d outputs want 0", seen); else pass_cnt++;
  endtask

  task automatic test_overflow();
    bit got; int lat; logic signed [15:0] od; logic [1:0] oc; exp_t e;
    logic signed [15:0] last_want;
`ifdef FIR_SAT_EN
    last_want = 16'sd32767;
`else
    last_want = 16'sd32727;
`endif
    pulse_reset();
    for (int k = 0; k < ORD; k++) write_coef(6'(k), 18'sd65536);
    for (int i = 0; i < ORD; i++) begin
      send_sample(16'sd32767, 2'd0, 1'b0, 6'd0, 18'sd0);
      get_output(got, lat, od, oc);
      e = sb_q.pop_front();
      total_cnt++;
      if (!got || od !== e.data)
        $display("FAIL overflow[%0d]: got valid=%b data=%0d want %0d", i, got, od, e.data);
      else pass_cnt++;
      if (i == ORD - 1) begin
        total_cnt++;
        if (od !== last_want) $display("FAIL overflow_last: got %0d want %0d", od, last_want); else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid_mac();
    bit got; int lat; int seen; logic signed [15:0] od; logic [1:0] oc; exp_t e;
    send_sample(16'sd1234, 2'd0, 1'b0, 6'd0, 18'sd0);
    repeat (20) @(negedge Clk);
    Rst = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL mid_mac_reset_flags: got in_ready=%b busy=%b out_valid=%b want 1 0 0", in_ready, busy, out_valid);
    else pass_cnt++;
    @(negedge Clk);
    Rst = 1'b0;
    model_reset();
    watch_quiet(60, seen);
    total_cnt++;
    if (seen !== 0) $display("FAIL mid_mac_discard: got %0d outputs want 0", seen); else pass_cnt++;
    send_sample(16'sd500, 2'd0, 1'b0, 6'd0, 18'sd0);
    get_output(got, lat, od, oc);
    e = sb_q.pop_front();
    total_cnt++;
    if (!got || od !== e.data || lat !== 42)
      $display("FAIL after_reset_identity: got valid=%b data=%0d lat=%0d want data=%0d lat=42", got, od, lat, e.data);
    else pass_cnt++;
  endtask

  task automatic test_handshake_timeouts();
    total_cnt++;
    if (hs_timeouts !== 0) $display("FAIL handshake_timeouts: got %0d want 0", hs_timeouts); else pass_cnt++;
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    model_reset();
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_impulse();
    test_channels();
    test_gating();
    test_overflow();
    test_reset_mid_mac();
    test_handshake_timeouts();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
